// File: rtl/bcpu_mem_arbiter.sv
// Round-robin arbiter giving four requesters shared access to one synchronous RAM port.
// Grants are registered one cycle after the request; read data returns one cycle after its grant.
module bcpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    HOLD,
  input  logic [3:0]              REQ,
  input  logic [3:0]              WE,
  input  logic [4*ADDR_WIDTH-1:0] ADDR,
  input  logic [4*DATA_WIDTH-1:0] WDATA,
  output logic [3:0]              GNT,
  output logic [3:0]              RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    MEM_EN,
  output logic                    MEM_WE,
  output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  output logic [DATA_WIDTH-1:0]   MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]   MEM_RDATA
);

  logic [1:0] ptr;
  logic [1:0] gnt_id;
  logic [1:0] rd_id;
  logic       rd_pend;
  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] winner;
  logic [1:0] cand;

  // Masking with the current grant keeps a requester from being granted twice in a row.
  always_comb begin
    eligible     = HOLD ? 4'b0000 : (REQ & ~GNT);
    any_eligible = |eligible;
    winner       = ptr;
    cand         = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (eligible[cand]) winner = cand;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      GNT       <= 4'b0000;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      ptr       <= 2'd0;
      gnt_id    <= 2'd0;
    end else if (any_eligible) begin
      GNT       <= 4'b0001 << winner;
      MEM_EN    <= 1'b1;
      MEM_WE    <= WE[winner];
      MEM_ADDR  <= ADDR[winner*ADDR_WIDTH +: ADDR_WIDTH];
      MEM_WDATA <= WDATA[winner*DATA_WIDTH +: DATA_WIDTH];
      ptr       <= winner + 2'd1;
      gnt_id    <= winner;
    end else begin
      GNT    <= 4'b0000;
      MEM_EN <= 1'b0;
    end
  end

  // The read stage captures the grant cycle so RVALID lines up with the RAM's one-cycle latency.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pend <= 1'b0;
      rd_id   <= 2'd0;
    end else begin
      rd_pend <= MEM_EN & ~MEM_WE;
      rd_id   <= gnt_id;
    end
  end

  assign RVALID = rd_pend ? (4'b0001 << rd_id) : 4'b0000;
  assign RDATA  = MEM_RDATA;

endmodule

// File: tb/tb_bcpu_mem_arbiter.sv
// Directed bench for bcpu_mem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_bcpu_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          CLK;
  logic          RESET_N;
  logic          HOLD;
  logic [3:0]    REQ;
  logic [3:0]    WE;
  logic [4*AW-1:0] ADDR;
  logic [4*DW-1:0] WDATA;
  logic [3:0]    GNT;
  logic [3:0]    RVALID;
  logic [DW-1:0] RDATA;
  logic          MEM_EN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  typedef struct packed {
    logic [3:0]    rv;
    logic [DW-1:0] data;
  } rd_t;

  rd_t sb [$];
  int  checks = 0;
  int  errors = 0;

  bcpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HOLD(HOLD), .REQ(REQ), .WE(WE),
    .ADDR(ADDR), .WDATA(WDATA), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous RAM with one-cycle read latency and a preload path for setup.
  always @(posedge CLK) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (MEM_EN) begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
      else MEM_RDATA <= ram[MEM_ADDR];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic hold, input logic [3:0] req, input logic [3:0] we);
    HOLD = hold;
    REQ  = req;
    WE   = we;
  endtask

  // Advance one cycle and retire any read return against the scoreboard.
  task automatic tick();
    rd_t e;
    @(posedge CLK);
    #1;
    if (RVALID !== 4'b0000) begin
      if (sb.size() == 0) checkOutput("rvalid_unexpected", 64'(RVALID), 64'h0);
      else begin
        e = sb.pop_front();
        checkOutput("sb_rvalid", 64'(RVALID), 64'(e.rv));
        checkOutput("sb_rdata", 64'(RDATA), 64'(e.data));
      end
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] gnt, input logic en);
    checkOutput({tag, "_gnt"}, 64'(GNT), 64'(gnt));
    checkOutput({tag, "_en"}, 64'(MEM_EN), 64'(en));
  endtask

  initial begin
    rd_t e;
    RESET_N  = 1'b0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    ADDR     = '0;
    WDATA    = '0;
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    #2;
    check_grant("reset", 4'b0000, 1'b0);
    checkOutput("reset_rvalid", 64'(RVALID), 64'h0);
    checkOutput("reset_mem_we", 64'(MEM_WE), 64'h0);
    checkOutput("reset_mem_addr", 64'(MEM_ADDR), 64'h0);
    checkOutput("reset_mem_wdata", 64'(MEM_WDATA), 64'h0);

    pre_en   = 1'b1;
    pre_addr = 10'h055;
    pre_data = 16'h1234;
    @(posedge CLK);
    #1;
    pre_en  = 1'b0;
    RESET_N = 1'b1;

    // Full rotation with every requester writing; each drops REQ for the cycle after its grant.
    for (int i = 0; i < 4; i++) begin
      ADDR[i*AW +: AW]  = AW'(10'h100 + i);
      WDATA[i*DW +: DW] = DW'(16'hA000 + i);
    end
    applyStimulus(1'b0, 4'b1111, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (i % 4);
      tick();
      check_grant("rr", exp_g, 1'b1);
      checkOutput("rr_addr", 64'(MEM_ADDR), 64'(10'h100 + (i % 4)));
      checkOutput("rr_rvalid", 64'(RVALID), 64'h0);
      applyStimulus(1'b0, 4'b1111 & ~exp_g, 4'b1111);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    check_grant("idle", 4'b0000, 1'b0);

    // Requester 2 reads preloaded location 0x055.
    ADDR[2*AW +: AW] = 10'h055;
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    tick();
    check_grant("rd2", 4'b0100, 1'b1);
    checkOutput("rd2_we", 64'(MEM_WE), 64'h0);
    checkOutput("rd2_addr", 64'(MEM_ADDR), 64'h055);
    e.rv = 4'b0100; e.data = 16'h1234; sb.push_back(e);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    checkOutput("rd2_rvalid", 64'(RVALID), 64'h4);
    checkOutput("rd2_rdata", 64'(RDATA), 64'h1234);

    // Requester 1 writes 0xBEEF to 0x3FF, then reads it back.
    ADDR[1*AW +: AW]  = 10'h3FF;
    WDATA[1*DW +: DW] = 16'hBEEF;
    applyStimulus(1'b0, 4'b0010, 4'b0010);
    tick();
    check_grant("wr1", 4'b0010, 1'b1);
    checkOutput("wr1_we", 64'(MEM_WE), 64'h1);
    checkOutput("wr1_addr", 64'(MEM_ADDR), 64'h3FF);
    checkOutput("wr1_wdata", 64'(MEM_WDATA), 64'hBEEF);
    checkOutput("wr1_rvalid", 64'(RVALID), 64'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    checkOutput("wr1_rvalid_after", 64'(RVALID), 64'h0);
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    tick();
    check_grant("rb1", 4'b0010, 1'b1);
    e.rv = 4'b0010; e.data = 16'hBEEF; sb.push_back(e);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    checkOutput("rb1_rvalid", 64'(RVALID), 64'h2);

    // Requester 3 alone: write, forced gap, then a read grant leaving the pointer at 0.
    ADDR[3*AW +: AW]  = 10'h200;
    WDATA[3*DW +: DW] = 16'h5A5A;
    applyStimulus(1'b0, 4'b1000, 4'b1000);
    tick();
    check_grant("r3a", 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    tick();
    check_grant("r3gap", 4'b0000, 1'b0);
    tick();
    check_grant("r3b", 4'b1000, 1'b1);
    checkOutput("r3b_addr", 64'(MEM_ADDR), 64'h200);
    checkOutput("r3b_ptr", 64'(dut.ptr), 64'h0);
    e.rv = 4'b1000; e.data = 16'h5A5A; sb.push_back(e);

    // HOLD for five cycles; the outstanding read must still return in the first one.
    ADDR[0*AW +: AW] = 10'h010;
    ADDR[1*AW +: AW] = 10'h011;
    applyStimulus(1'b1, 4'b0011, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant("hold", 4'b0000, 1'b0);
      if (i == 0) checkOutput("hold_rvalid", 64'(RVALID), 64'h8);
    end
    applyStimulus(1'b0, 4'b0011, 4'b0011);
    tick();
    check_grant("hold_release", 4'b0001, 1'b1);
    checkOutput("hold_release_addr", 64'(MEM_ADDR), 64'h010);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();

    // Reset asserted during a read-return cycle discards the return.
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    tick();
    check_grant("rst_rd", 4'b0100, 1'b1);
    e.rv = 4'b0100; e.data = 16'h1234; sb.push_back(e);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    checkOutput("rst_rd_rvalid_pre", 64'(RVALID), 64'h4);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("rst_rvalid", 64'(RVALID), 64'h0);
    check_grant("rst", 4'b0000, 1'b0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("post_rst_rvalid", 64'(RVALID), 64'h0);
      check_grant("post_rst", 4'b0000, 1'b0);
    end

    // First arbitration after reset starts from requester 0.
    applyStimulus(1'b0, 4'b1111, 4'b1111);
    tick();
    check_grant("post_rst_arb", 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    tick();
    tick();

    checkOutput("sb_empty", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcpu_mem_arbiter.md
BCPU_MEM_ARBITER -- requirements
Module: bcpu_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the width of the memory word address.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the width of the memory data word.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port CLK, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port HOLD, input, 1 bit: when 1, no new grants are issued.
REQ-007 The block SHALL have port REQ, input, 4 bits: per-requester access request, held until granted.
REQ-008 The block SHALL have port WE, input, 4 bits: per-requester write enable (1 write, 0 read).
REQ-009 The block SHALL have port ADDR, input, 4*ADDR_WIDTH bits: per-requester address; requester i occupies slice i.
REQ-010 The block SHALL have port WDATA, input, 4*DATA_WIDTH bits: per-requester write data; requester i occupies slice i.
REQ-011 The block SHALL have port GNT, output, 4 bits: one-cycle grant pulse, at most one bit set.
REQ-012 The block SHALL have port RVALID, output, 4 bits: one-cycle read-data-valid pulse, at most one bit set.
REQ-013 The block SHALL have port RDATA, output, DATA_WIDTH bits: read data, valid when any RVALID bit is set.
REQ-014 The block SHALL have ports MEM_EN (1), MEM_WE (1), MEM_ADDR (ADDR_WIDTH) and MEM_WDATA (DATA_WIDTH), all outputs, driving the synchronous RAM port.
REQ-015 The block SHALL have port MEM_RDATA, input, DATA_WIDTH bits: RAM read data, valid one cycle after the cycle in which MEM_EN=1 and MEM_WE=0.

Function
REQ-016 At each rising edge the block SHALL compute the eligible set as REQ & ~GNT, forced empty when HOLD=1.
REQ-017 The block SHALL select the winner round-robin from the eligible set, searching upward from pointer PTR (2 bits) with wrap 3->0.
REQ-018 When the eligible set is non-empty, the block SHALL, on that edge, register GNT=onehot(winner), MEM_EN=1, MEM_WE=WE[winner], MEM_ADDR=ADDR slice winner, MEM_WDATA=WDATA slice winner, and PTR=winner+1 mod 4.
REQ-019 When the eligible set is empty, the block SHALL register GNT=0 and MEM_EN=0, hold PTR, and keep MEM_ADDR/MEM_WDATA at their previous values.
REQ-020 Grant latency SHALL be 1 cycle: REQ sampled at edge t gives GNT during cycle t..t+1.
REQ-021 A requester SHALL never be granted in two consecutive cycles; a requester sees GNT and then drops REQ or presents a new request.
REQ-022 Reads SHALL be tracked through a 1-stage pipeline (RD_ID 2 bits, RD_PEND 1 bit) loaded at grant time.
REQ-023 RVALID[RD_ID] SHALL be 1 exactly in the cycle after a read grant cycle.
REQ-024 RDATA SHALL pass MEM_RDATA through combinationally.
REQ-025 RVALID SHALL be 0 after a write grant.
REQ-026 Back-to-back grants to different requesters SHALL be supported at one access per cycle, with read returns in issue order.
REQ-027 HOLD asserted in the cycle after a read grant SHALL still deliver that read's RVALID.
REQ-028 HOLD SHALL block only new grants.
REQ-029 Requesters with WE=1 and WE=0 SHALL be arbitrated identically.
REQ-030 The block SHALL have no priority except PTR order.

Reset
REQ-031 While RESET_N=0, the block SHALL drive GNT=0, RVALID=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, PTR=0 and RD_PEND=0, independent of CLK.
REQ-032 A reset during an outstanding read SHALL discard that read: no RVALID after release.
REQ-033 The first edge after reset release SHALL arbitrate normally with PTR=0.

Verification
REQ-034 The bench SHALL check: REQ=4'b1111 held, each requester dropping REQ for 1 cycle after its GNT -> GNT sequence 0001, 0010, 0100, 1000, 0001.
REQ-035 The bench SHALL check: requester 2 read at addr 0x055, RAM holding 0x1234 there -> GNT=0100 at cycle 1, MEM_EN=1, MEM_WE=0, MEM_ADDR=0x055, then RVALID=0100 with RDATA=0x1234 at cycle 2.
REQ-036 The bench SHALL check: requester 1 write addr 0x3FF data 0xBEEF -> MEM_WE=1, MEM_ADDR=0x3FF, MEM_WDATA=0xBEEF, RVALID=0 throughout.
REQ-037 The bench SHALL check: HOLD=1 with REQ=4'b0011 for 5 cycles -> GNT=0 and MEM_EN=0 for all 5; HOLD falling -> GNT=0001 at the next edge.
REQ-038 The bench SHALL check: requester 3 granted, then only requester 3 still requesting -> GNT=0 for one cycle, then GNT=1000 again, PTR=0.
REQ-039 The bench SHALL check: RESET_N pulsed low during the read-return cycle -> RVALID=0 immediately and no RVALID after release.
